paddle_driver: RTL and testbench
================================

# paddle_driver

Downstream stage of the AI paddle controller. Once per game frame it samples the controller's 3-bit `action` code after a fixed settle delay. It converts that code into a ramped vertical step and applies the step to both AI-team paddles, clamping each paddle to the playfield. Its registered paddle Y outputs feed the game server's paddle state, which in turn feeds back into the AI controller's `paddle10_posy` and `paddle11_posy` inputs.

## Interface
- `FIELD_H`, 480: playfield height in pixels.
- `HALF_PAD`, 40: half paddle height. Legal centre range is [HALF_PAD, FIELD_H-HALF_PAD].
- `INIT_Y10`, 240: reset Y of paddle 10.
- `INIT_Y11`, 240: reset Y of paddle 11.
- `STEP_MIN`, 2: first step after HOLD or a direction change.
- `STEP_MAX`, 8: speed ceiling.
- `ACCEL`, 2: speed increment per consecutive same-direction frame.
- `SETTLE`, 3: clock edges from tick acceptance to action sample. Range 1..15. Covers the controller's register plus RAM read latency.

Ports:
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `frame_tick` input 1: one-cycle pulse per game frame.
- `action` input 3: controller code. 1=HOLD, 2=UP (+y), 3=DOWN (-y).
- `paddle10_posy` output 11 signed: paddle 10 centre Y.
- `paddle11_posy` output 11 signed: paddle 11 centre Y.
- `speed` output 5: current step magnitude.
- `dir` output 2: 0 = none, 1 = up, 2 = down.
- `update` output 1: one-cycle pulse after the positions change.
- `overrun` output 1: sticky. A frame_tick arrived while the block was busy.
- `illegal` output 1: sticky. An action code of 0 or 4..7 was sampled.

## Operation
- FSM states:
  - IDLE: a `frame_tick`=1 edge loads `cnt`=SETTLE and moves to WAIT.
  - WAIT: `cnt` decrements each edge. The edge on which `cnt`==1 is the sample edge. It samples `action`, updates dir, speed and positions, and returns to IDLE.
- Decode, evaluated against the previous `dir`:
  - HOLD: speed←0, dir←0, positions unchanged.
  - UP or DOWN equal to the previous dir: speed←min(speed+ACCEL, STEP_MAX).
  - UP or DOWN with a different or zero previous dir: speed←STEP_MIN, dir←new.
  - Illegal code: treated as HOLD, and `illegal` is set.
- Position update: pos_next = pos ± speed_next, computed in 12-bit signed arithmetic. Each paddle is then clamped independently to [HALF_PAD, FIELD_H-HALF_PAD].
- Clamping does not reset the speed; the ramp continues while the paddle is pinned.
- Both paddles always use the same step.
- `frame_tick` in WAIT is dropped and sets `overrun`. It is never queued.
- `overrun` and `illegal` clear only on reset.

## Timing
- Reset values, asynchronous on `rst_n`=0:
  - FSM=IDLE, `cnt`=0.
  - `paddle10_posy`=INIT_Y10, `paddle11_posy`=INIT_Y11.
  - `speed`=0, `dir`=0.
  - `update`=0, `overrun`=0, `illegal`=0.
- Latency: if tick acceptance happens at edge E, `action` is sampled at edge E+SETTLE. The new positions, speed and dir are visible after that edge. `update` is high for exactly that cycle, from E+SETTLE to E+SETTLE+1.
- A tick arriving at the sample edge itself is dropped and counted as overrun. A tick on the following edge is accepted.
- Reset asserted mid-WAIT aborts the frame: no position update, no `update` pulse.
- Reset release is synchronised by the surrounding top. The block accepts a tick on the first edge after release.
- All outputs are registered. None is combinational from `action` or `frame_tick`.

## Test plan
- Reset: assert `rst_n`=0 mid-run → both positions 240, speed 0, dir 0, all flags 0 immediately, before any clock edge.
- Ramp: action=2 held, five ticks spaced 10 cycles apart → positions 242, 246, 252, 260, 268. Speed 2, 4, 6, 8, 8. `update` pulses exactly 3 edges after each tick.
- Direction change and hold: from speed 8 UP, action=3 → speed 2, position −2. Then action=1 → speed 0, dir 0, position unchanged.
- Clamp: both paddles at 436, speed 6, UP → next tick 440 with speed 8, then 440 again with speed 8. DOWN from 44 at STEP_MIN → 42, next frame → 40.
- Overrun and illegal:
  - Tick, then a second tick 1 cycle later → one update only, `overrun`=1.
  - Sample action=0 → treated as HOLD, `illegal`=1. Both flags persist until reset.
- Mid-operation reset: tick at edge E, reset at E+1 → positions stay at their INIT values and no `update` pulse occurs.

Source files
------------

// File: rtl/paddle_driver_if.sv
// Frame-tick/action inputs and paddle state outputs of paddle_driver.
// master: the driving controller side; slave: the paddle_driver itself.
interface paddle_driver_if;
  logic               frame_tick;
  logic [2:0]         action;
  logic signed [10:0] paddle10_posy;
  logic signed [10:0] paddle11_posy;
  logic [4:0]         speed;
  logic [1:0]         dir;
  logic               update;
  logic               overrun;
  logic               illegal;

  modport master (
    output frame_tick,
    output action,
    input  paddle10_posy,
    input  paddle11_posy,
    input  speed,
    input  dir,
    input  update,
    input  overrun,
    input  illegal
  );

  modport slave (
    input  frame_tick,
    input  action,
    output paddle10_posy,
    output paddle11_posy,
    output speed,
    output dir,
    output update,
    output overrun,
    output illegal
  );
endinterface

// File: rtl/paddle_driver.sv
// Samples the AI action once per frame after a settle delay and
// moves both AI paddles by a ramped, clamped vertical step.
module paddle_driver #(
  parameter int FIELD_H  = 480,
  parameter int HALF_PAD = 40,
  parameter int INIT_Y10 = 240,
  parameter int INIT_Y11 = 240,
  parameter int STEP_MIN = 2,
  parameter int STEP_MAX = 8,
  parameter int ACCEL    = 2,
  parameter int SETTLE   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  paddle_driver_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DN   = 2'd2;

  localparam logic [2:0] ACT_HOLD = 3'd1;
  localparam logic [2:0] ACT_UP   = 3'd2;
  localparam logic [2:0] ACT_DN   = 3'd3;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE);
  localparam logic [4:0] SMIN     = 5'(STEP_MIN);
  localparam logic [4:0] SMAX     = 5'(STEP_MAX);
  localparam logic [4:0] SACC     = 5'(ACCEL);

  localparam logic signed [11:0] Y_LO = 12'(HALF_PAD);
  localparam logic signed [11:0] Y_HI = 12'(FIELD_H - HALF_PAD);

  localparam logic signed [10:0] Y10_RST = 11'(INIT_Y10);
  localparam logic signed [10:0] Y11_RST = 11'(INIT_Y11);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_nxt;
  logic               w_sample;
  logic               w_drop;

  logic signed [10:0] r_y10;
  logic signed [10:0] r_y11;
  logic [4:0]         r_speed;
  logic [1:0]         r_dir;
  logic               r_update;
  logic               r_overrun;
  logic               r_illegal;

  logic               w_up;
  logic               w_dn;
  logic               w_bad;
  logic [1:0]         w_dir_nxt;
  logic [4:0]         w_speed_nxt;
  logic [5:0]         w_sum;
  logic signed [11:0] w_step;
  logic signed [11:0] w_y10_raw;
  logic signed [11:0] w_y11_raw;
  logic signed [10:0] w_y10_nxt;
  logic signed [10:0] w_y11_nxt;

  function automatic logic signed [10:0] clamp_y(
    input logic signed [11:0] v
  );
    if (v < Y_LO)
      return 11'(Y_LO);
    else if (v > Y_HI)
      return 11'(Y_HI);
    else
      return 11'(v);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sample    = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.frame_tick) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_WAIT: begin
        w_drop    = bus.frame_tick;
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_sample    = 1'b1;
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      end
    endcase
  end

  assign w_up  = (bus.action == ACT_UP);
  assign w_dn  = (bus.action == ACT_DN);
  assign w_sum = {1'b0, r_speed} + {1'b0, SACC};

  // Illegal codes fall through to the HOLD path.
  always_comb begin
    w_dir_nxt   = DIR_NONE;
    w_speed_nxt = 5'd0;
    w_bad       = 1'b0;
    unique case (1'b1)
      w_up:    w_dir_nxt = DIR_UP;
      w_dn:    w_dir_nxt = DIR_DN;
      default: w_bad = (bus.action != ACT_HOLD);
    endcase
    if (w_dir_nxt != DIR_NONE) begin
      if (w_dir_nxt == r_dir)
        w_speed_nxt = (w_sum > {1'b0, SMAX}) ? SMAX : w_sum[4:0];
      else
        w_speed_nxt = SMIN;
    end
  end

  assign w_step = $signed({7'd0, w_speed_nxt});

  always_comb begin
    w_y10_raw = {r_y10[10], r_y10};
    w_y11_raw = {r_y11[10], r_y11};
    unique case (w_dir_nxt)
      DIR_UP: begin
        w_y10_raw = {r_y10[10], r_y10} + w_step;
        w_y11_raw = {r_y11[10], r_y11} + w_step;
      end
      DIR_DN: begin
        w_y10_raw = {r_y10[10], r_y10} - w_step;
        w_y11_raw = {r_y11[10], r_y11} - w_step;
      end
      default: ;
    endcase
  end

  assign w_y10_nxt = clamp_y(w_y10_raw);
  assign w_y11_nxt = clamp_y(w_y11_raw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y10     <= Y10_RST;
      r_y11     <= Y11_RST;
      r_speed   <= 5'd0;
      r_dir     <= DIR_NONE;
      r_update  <= 1'b0;
      r_overrun <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_update <= w_sample;
      if (w_sample) begin
        r_y10   <= w_y10_nxt;
        r_y11   <= w_y11_nxt;
        r_speed <= w_speed_nxt;
        r_dir   <= w_dir_nxt;
        if (w_bad)
          r_illegal <= 1'b1;
      end
      if (w_drop)
        r_overrun <= 1'b1;
    end
  end

  assign bus.paddle10_posy = r_y10;
  assign bus.paddle11_posy = r_y11;
  assign bus.speed         = r_speed;
  assign bus.dir           = r_dir;
  assign bus.update        = r_update;
  assign bus.overrun       = r_overrun;
  assign bus.illegal       = r_illegal;

endmodule

// File: tb/tb_paddle_driver.sv
// Directed bench for paddle_driver: reset, ramp, reversal, clamp,
// overrun/illegal flags and mid-frame reset.
module tb_paddle_driver;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   lat;
  int   n_upd;

  paddle_driver_if u_if ();

  paddle_driver u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    u_if.frame_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic frame(input logic [2:0] act, output int l);
    @(negedge clk);
    u_if.action = act;
    u_if.frame_tick = 1'b1;
    @(negedge clk);
    u_if.frame_tick = 1'b0;
    l = 0;
    while (u_if.update !== 1'b1 && l < 20) begin
      @(negedge clk);
      l++;
    end
    n_cmp++;
    if (l >= 20) begin
      n_err++;
      $display("FAIL frame_timeout: waited %0d cycles, required update within 20", l);
    end
  endtask

  task automatic frames(input logic [2:0] act, input int n);
    for (int k = 0; k < n; k++) frame(act, lat);
  endtask

  task automatic test_reset();
    do_reset();
    frame(3'd2, lat);
    frame(3'd0, lat);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (u_if.paddle10_posy !== 11'sd240 || u_if.paddle11_posy !== 11'sd240) begin
      n_err++;
      $display("FAIL reset_pos: got %0d/%0d, required 240/240",
               u_if.paddle10_posy, u_if.paddle11_posy);
    end
    n_cmp++;
    if (u_if.speed !== 5'd0 || u_if.dir !== 2'd0) begin
      n_err++;
      $display("FAIL reset_speed_dir: got %0d/%0d, required 0/0", u_if.speed, u_if.dir);
    end
    n_cmp++;
    if ({u_if.update, u_if.overrun, u_if.illegal} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b, required 000",
               {u_if.update, u_if.overrun, u_if.illegal});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    int exp_y[5];
    int exp_s[5];
    exp_y = '{242, 246, 252, 260, 268};
    exp_s = '{2, 4, 6, 8, 8};
    for (int i = 0; i < 5; i++) begin
      frame(3'd2, lat);
      n_cmp++;
      if (lat !== 3) begin
        n_err++;
        $display("FAIL ramp_latency[%0d]: got %0d, required 3", i, lat);
      end
      n_cmp++;
      if (u_if.paddle10_posy !== 11'(exp_y[i]) || u_if.paddle11_posy !== 11'(exp_y[i])) begin
        n_err++;
        $display("FAIL ramp_pos[%0d]: got %0d/%0d, required %0d", i,
                 u_if.paddle10_posy, u_if.paddle11_posy, exp_y[i]);
      end
      n_cmp++;
      if (u_if.speed !== 5'(exp_s[i]) || u_if.dir !== 2'd1) begin
        n_err++;
        $display("FAIL ramp_speed[%0d]: got %0d dir %0d, required %0d dir 1", i,
                 u_if.speed, u_if.dir, exp_s[i]);
      end
      @(negedge clk);
      n_cmp++;
      if (u_if.update !== 1'b0) begin
        n_err++;
        $display("FAIL ramp_update_width[%0d]: got %b, required 0", i, u_if.update);
      end
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_dir_hold();
    frame(3'd3, lat);
    n_cmp++;
    if (u_if.paddle10_posy !== 11'sd266 || u_if.speed !== 5'd2 || u_if.dir !== 2'd2) begin
      n_err++;
      $display("FAIL reverse: got y=%0d s=%0d d=%0d, required y=266 s=2 d=2",
               u_if.paddle10_posy, u_if.speed, u_if.dir);
    end
    frame(3'd1, lat);
    n_cmp++;
    if (u_if.paddle11_posy !== 11'sd266 || u_if.speed !== 5'd0 || u_if.dir !== 2'd0) begin
      n_err++;
      $display("FAIL hold: got y=%0d s=%0d d=%0d, required y=266 s=0 d=0",
               u_if.paddle11_posy, u_if.speed, u_if.dir);
    end
  endtask

  task automatic test_clamp_up();
    do_reset();
    frames(3'd2, 24);
    frame(3'd1, lat);
    frame(3'd2, lat);
    frame(3'd1, lat);
    frame(3'd2, lat);
    frame(3'd1, lat);
    frames(3'd2, 3);
    n_cmp++;
    if (u_if.paddle10_posy !== 11'sd436 || u_if.speed !== 5'd6) begin
      n_err++;
      $display("FAIL clamp_up_setup: got y=%0d s=%0d, required y=436 s=6",
               u_if.paddle10_posy, u_if.speed);
    end
    for (int i = 0; i < 2; i++) begin
      frame(3'd2, lat);
      n_cmp++;
      if (u_if.paddle10_posy !== 11'sd440 || u_if.paddle11_posy !== 11'sd440 ||
          u_if.speed !== 5'd8) begin
        n_err++;
        $display("FAIL clamp_up[%0d]: got %0d/%0d s=%0d, required 440/440 s=8", i,
                 u_if.paddle10_posy, u_if.paddle11_posy, u_if.speed);
      end
    end
  endtask

  task automatic test_clamp_down();
    do_reset();
    frames(3'd3, 26);
    frame(3'd1, lat);
    n_cmp++;
    if (u_if.paddle10_posy !== 11'sd44) begin
      n_err++;
      $display("FAIL clamp_dn_setup: got %0d, required 44", u_if.paddle10_posy);
    end
    frame(3'd3, lat);
    n_cmp++;
    if (u_if.paddle10_posy !== 11'sd42 || u_if.speed !== 5'd2) begin
      n_err++;
      $display("FAIL clamp_dn_first: got y=%0d s=%0d, required y=42 s=2",
               u_if.paddle10_posy, u_if.speed);
    end
    frame(3'd3, lat);
    n_cmp++;
    if (u_if.paddle10_posy !== 11'sd40 || u_if.paddle11_posy !== 11'sd40 ||
        u_if.speed !== 5'd4) begin
      n_err++;
      $display("FAIL clamp_dn_pin: got %0d/%0d s=%0d, required 40/40 s=4",
               u_if.paddle10_posy, u_if.paddle11_posy, u_if.speed);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    @(negedge clk);
    u_if.action = 3'd2;
    u_if.frame_tick = 1'b1;
    repeat (2) @(negedge clk);
    u_if.frame_tick = 1'b0;
    n_upd = 0;
    for (int i = 0; i < 12; i++) begin
      if (u_if.update === 1'b1) n_upd++;
      @(negedge clk);
    end
    n_cmp++;
    if (n_upd !== 1 || u_if.overrun !== 1'b1 || u_if.paddle10_posy !== 11'sd242) begin
      n_err++;
      $display("FAIL overrun_double: got upd=%0d ovr=%b y=%0d, required 1/1/242",
               n_upd, u_if.overrun, u_if.paddle10_posy);
    end
    do_reset();
    @(negedge clk);
    u_if.frame_tick = 1'b1;
    @(negedge clk);
    u_if.frame_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    u_if.frame_tick = 1'b1;
    @(negedge clk);
    n_upd = (u_if.update === 1'b1) ? 1 : 0;
    @(negedge clk);
    u_if.frame_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (u_if.update === 1'b1) n_upd++;
      @(negedge clk);
    end
    n_cmp++;
    if (n_upd !== 2 || u_if.overrun !== 1'b1 || u_if.paddle10_posy !== 11'sd246) begin
      n_err++;
      $display("FAIL overrun_sample_edge: got upd=%0d ovr=%b y=%0d, required 2/1/246",
               n_upd, u_if.overrun, u_if.paddle10_posy);
    end
  endtask

  task automatic test_illegal();
    frame(3'd0, lat);
    n_cmp++;
    if (u_if.paddle10_posy !== 11'sd246 || u_if.speed !== 5'd0 ||
        u_if.dir !== 2'd0 || u_if.illegal !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_hold: got y=%0d s=%0d d=%0d ill=%b, required 246/0/0/1",
               u_if.paddle10_posy, u_if.speed, u_if.dir, u_if.illegal);
    end
    frame(3'd2, lat);
    n_cmp++;
    if (u_if.paddle10_posy !== 11'sd248 || u_if.illegal !== 1'b1 ||
        u_if.overrun !== 1'b1) begin
      n_err++;
      $display("FAIL flags_sticky: got y=%0d ill=%b ovr=%b, required 248/1/1",
               u_if.paddle10_posy, u_if.illegal, u_if.overrun);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    frame(3'd2, lat);
    @(negedge clk);
    u_if.frame_tick = 1'b1;
    @(negedge clk);
    u_if.frame_tick = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_upd = 0;
    for (int i = 0; i < 10; i++) begin
      if (u_if.update === 1'b1) n_upd++;
      @(negedge clk);
    end
    n_cmp++;
    if (n_upd !== 0 || u_if.paddle10_posy !== 11'sd240 || u_if.paddle11_posy !== 11'sd240) begin
      n_err++;
      $display("FAIL midreset_abort: got upd=%0d y=%0d/%0d, required 0 240/240",
               n_upd, u_if.paddle10_posy, u_if.paddle11_posy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    u_if.action = 3'd2;
    u_if.frame_tick = 1'b1;
    @(negedge clk);
    u_if.frame_tick = 1'b0;
    lat = 0;
    while (u_if.update !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 3 || u_if.paddle10_posy !== 11'sd242) begin
      n_err++;
      $display("FAIL release_accept: got lat=%0d y=%0d, required 3/242",
               lat, u_if.paddle10_posy);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    lat = 0;
    n_upd = 0;
    rst_n = 1'b0;
    u_if.frame_tick = 1'b0;
    u_if.action = 3'd1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_ramp();
    test_dir_hold();
    test_clamp_up();
    test_clamp_down();
    test_overrun();
    test_illegal();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
